visitor_count_ctrl: RTL

//  Sequencing controller for the bidirectional visitor counter. Two beam sensors
//  (outer A, inner B) are synchronised and debounced. A direction FSM classifies

---
 rtl/visitor_pkg.sv | 21 ++
 rtl/half_subtractor.sv | 12 +
 rtl/vc_sensor_filter.sv | 40 ++++
 rtl/visitor_count_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/visitor_pkg.sv
// rtl/visitor_pkg.sv - shared state and sensor-code definitions for the visitor counter
package visitor_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EN1      = 3'd1,
        EN2      = 3'd2,
        EN3      = 3'd3,
        EX1      = 3'd4,
        EX2      = 3'd5,
        EX3      = 3'd6,
        WAIT_CLR = 3'd7
    } state_t;

    // Sensor code is {a, b}
    localparam logic [1:0] S_NONE = 2'b00;
    localparam logic [1:0] S_A    = 2'b10;
    localparam logic [1:0] S_B    = 2'b01;
    localparam logic [1:0] S_AB   = 2'b11;

endpackage

// File: rtl/half_subtractor.sv
// rtl/half_subtractor.sv - one-bit half subtractor cell, d = a - b with borrow out
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bout
);

    assign d    = a ^ b;
    assign bout = ~a & b;

endmodule

// File: rtl/vc_sensor_filter.sv
// rtl/vc_sensor_filter.sv - two-flop synchroniser plus debounce for one beam sensor
module vc_sensor_filter #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CW = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // cnt tracks how many consecutive synchronised samples disagree with dout
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            dout  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 != dout) begin
                if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                    dout <= sync2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/visitor_count_ctrl.sv
// rtl/visitor_count_ctrl.sv - direction FSM, passage timeout and occupancy register
module visitor_count_ctrl
    import visitor_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int MAX_COUNT    = 99,
    parameter int DEBOUNCE_CYC = 4,
    parameter int TIMEOUT_CYC  = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor_a,
    input  logic             sensor_b,
    output logic [WIDTH-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             entry_p,
    output logic             exit_p,
    output logic             reject_p,
    output logic             abort_p
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic       a_db;
    logic       b_db;
    logic [1:0] code;

    state_t     state;
    state_t     state_nx;
    logic       req_entry_nx, req_exit_nx, req_abort_nx;
    logic       req_entry_q, req_exit_q, req_abort_q;
    logic [TW-1:0] tmr;
    logic       tmo;

    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] borrow;
    logic             dec_ok;

    vc_sensor_filter #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_filt_a (
        .clk (clk),
        .rst (rst),
        .din (sensor_a),
        .dout(a_db)
    );

    vc_sensor_filter #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_filt_b (
        .clk (clk),
        .rst (rst),
        .din (sensor_b),
        .dout(b_db)
    );

    assign code = {a_db, b_db};
    assign tmo  = (tmr == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_nx     = state;
        req_entry_nx = 1'b0;
        req_exit_nx  = 1'b0;
        req_abort_nx = 1'b0;
        case (state)
            IDLE: case (code)
                S_A:     state_nx = EN1;
                S_B:     state_nx = EX1;
                S_AB:    begin state_nx = WAIT_CLR; req_abort_nx = 1'b1; end
                default: ;
            endcase
            EN1: case (code)
                S_AB:    state_nx = EN2;
                S_NONE:  begin state_nx = IDLE;     req_abort_nx = 1'b1; end
                S_B:     begin state_nx = WAIT_CLR; req_abort_nx = 1'b1; end
                default: ;
            endcase
            EN2: case (code)
                S_B:     state_nx = EN3;
                S_A:     state_nx = EN1;
                S_NONE:  begin state_nx = IDLE; req_abort_nx = 1'b1; end
                default: ;
            endcase
            EN3: case (code)
                S_NONE:  begin state_nx = IDLE;     req_entry_nx = 1'b1; end
                S_AB:    state_nx = EN2;
                S_A:     begin state_nx = WAIT_CLR; req_abort_nx = 1'b1; end
                default: ;
            endcase
            EX1: case (code)
                S_AB:    state_nx = EX2;
                S_NONE:  begin state_nx = IDLE;     req_abort_nx = 1'b1; end
                S_A:     begin state_nx = WAIT_CLR; req_abort_nx = 1'b1; end
                default: ;
            endcase
            EX2: case (code)
                S_A:     state_nx = EX3;
                S_B:     state_nx = EX1;
                S_NONE:  begin state_nx = IDLE; req_abort_nx = 1'b1; end
                default: ;
            endcase
            EX3: case (code)
                S_NONE:  begin state_nx = IDLE;     req_exit_nx = 1'b1; end
                S_AB:    state_nx = EX2;
                S_B:     begin state_nx = WAIT_CLR; req_abort_nx = 1'b1; end
                default: ;
            endcase
            WAIT_CLR: if (code == S_NONE) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
        // A sensor-driven move wins over a timeout landing in the same cycle
        if (state_nx == state && state != IDLE && state != WAIT_CLR && tmo) begin
            state_nx     = WAIT_CLR;
            req_abort_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tmr         <= '0;
            req_entry_q <= 1'b0;
            req_exit_q  <= 1'b0;
            req_abort_q <= 1'b0;
        end else begin
            state       <= state_nx;
            req_entry_q <= req_entry_nx;
            req_exit_q  <= req_exit_nx;
            req_abort_q <= req_abort_nx;
            if (state_nx != state || state == IDLE || state == WAIT_CLR) begin
                tmr <= '0;
            end else begin
                tmr <= tmr + 1'b1;
            end
        end
    end

    // Borrow out of the top cell means count was zero, so the decrement is refused
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
        if (gi == 0) begin : g_lsb
            half_subtractor u_hs (.a(count[0]), .b(1'b1), .d(dec[0]), .bout(borrow[0]));
        end else begin : g_bit
            half_subtractor u_hs (.a(count[gi]), .b(borrow[gi-1]), .d(dec[gi]), .bout(borrow[gi]));
        end
    end

    assign dec_ok = ~borrow[WIDTH-1];

    // Pulses all come one cycle after the FSM transition that requested them
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            entry_p  <= 1'b0;
            exit_p   <= 1'b0;
            reject_p <= 1'b0;
            abort_p  <= 1'b0;
        end else begin
            entry_p  <= 1'b0;
            exit_p   <= 1'b0;
            reject_p <= 1'b0;
            abort_p  <= req_abort_q;
            if (req_entry_q) begin
                if (count < WIDTH'(MAX_COUNT)) begin
                    count   <= count + WIDTH'(1);
                    entry_p <= 1'b1;
                end else begin
                    reject_p <= 1'b1;
                end
            end else if (req_exit_q) begin
                if (dec_ok) begin
                    count  <= dec;
                    exit_p <= 1'b1;
                end else begin
                    reject_p <= 1'b1;
                end
            end
        end
    end

    assign full  = (count == WIDTH'(MAX_COUNT));
    assign empty = (count == '0);

endmodule
